// File: rtl/serial_pattern_checker_if.sv
// Serial pattern checker bus: the incoming serial line plus the checker's status outputs.
//   iSIG    : serial line from the pattern generator (driven by master)
//   oMATCH  : one-cycle pulse per correctly received frame (driven by slave)
//   oLOCK   : high while the checker is locked (driven by slave)
//   oERR    : one-cycle pulse on a bit mismatch after acquisition (driven by slave)
//   oFRAMES : saturating count of oMATCH pulses (driven by slave)
interface serial_pattern_checker_if;
    logic       iSIG;
    logic       oMATCH;
    logic       oLOCK;
    logic       oERR;
    logic [7:0] oFRAMES;

    // Pattern source side
    modport master (
        output iSIG,
        input  oMATCH,
        input  oLOCK,
        input  oERR,
        input  oFRAMES
    );

    // Checker side
    modport slave (
        input  iSIG,
        output oMATCH,
        output oLOCK,
        output oERR,
        output oFRAMES
    );
endinterface

// File: rtl/serial_pattern_checker.sv
// Serial pattern checker: oversamples a serial line at mid-bit, hunts for a 10-bit
// frame, then verifies every following frame bit by bit and reports lock/errors.
//   iCLK  : system clock, rising edge
//   iRST  : synchronous active-high reset
//   sp_if : slave modport (iSIG in; oMATCH, oLOCK, oERR, oFRAMES out)
module serial_pattern_checker #(
    parameter int unsigned DIV         = 6250000,
    parameter logic [9:0]  PATTERN     = 10'b1011011100,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    serial_pattern_checker_if.slave  sp_if
);
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned HALF  = DIV / 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               prev_q, prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [9:0]         shreg_q, shreg_d;
    logic [3:0]         fill_q, fill_d;
    logic [3:0]         good_q, good_d;
    logic [3:0]         pos_q, pos_d;
    logic               match_q, match_d;
    logic               err_q, err_d;
    logic               lock_q, lock_d;
    logic [7:0]         frames_q, frames_d;

    logic               s_sig;
    logic               edge_c;
    logic               strobe_c;
    logic [9:0]         sh_post;
    logic [3:0]         fill_inc;
    logic [3:0]         good_inc;
    logic               pat_bit;

    assign s_sig = sync2_q;

    // State and datapath registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= SEARCH;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            shreg_q  <= '0;
            fill_q   <= '0;
            good_q   <= '0;
            pos_q    <= '0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
            lock_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            fill_q   <= fill_d;
            good_q   <= good_d;
            pos_q    <= pos_d;
            match_q  <= match_d;
            err_q    <= err_d;
            lock_q   <= lock_d;
            frames_q <= frames_d;
        end
    end

    // Next-state, bit timing and frame checking
    always_comb begin
        state_d  = state_q;
        sync1_d  = sp_if.iSIG;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        fill_d   = fill_q;
        good_d   = good_q;
        pos_d    = pos_q;
        match_d  = 1'b0;
        err_d    = 1'b0;
        frames_d = frames_q;

        edge_c   = s_sig ^ prev_q;
        strobe_c = (cnt_q == CNT_W'(HALF));
        sh_post  = {shreg_q[8:0], s_sig};
        fill_inc = (fill_q == 4'd10) ? 4'd10 : fill_q + 4'd1;
        good_inc = good_q + 4'd1;
        pat_bit  = PATTERN[4'd9 - pos_q];

        // Bit-edge realignment only while hunting; afterwards the divider free-runs
        if (state_q == SEARCH && edge_c) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            SEARCH: begin
                if (strobe_c) begin
                    shreg_d = sh_post;
                    fill_d  = fill_inc;
                    if (fill_inc == 4'd10 && sh_post == PATTERN) begin
                        match_d = 1'b1;
                        good_d  = 4'd1;
                        pos_d   = 4'd0;
                        state_d = (LOCK_FRAMES == 1) ? LOCKED : VERIFY;
                    end
                end
            end
            VERIFY, LOCKED: begin
                if (strobe_c) begin
                    if (s_sig == pat_bit) begin
                        pos_d = (pos_q == 4'd9) ? 4'd0 : pos_q + 4'd1;
                        if (pos_q == 4'd9) begin
                            match_d = 1'b1;
                            if (state_q == VERIFY) begin
                                good_d = good_inc;
                                if (good_inc == 4'(LOCK_FRAMES)) begin
                                    state_d = LOCKED;
                                end
                            end
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = SEARCH;
                        shreg_d = '0;
                        fill_d  = '0;
                        good_d  = '0;
                        pos_d   = '0;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase

        if (match_d && frames_q != 8'hFF) begin
            frames_d = frames_q + 8'd1;
        end
        // Registered from the next state so it changes on the same edge as the state
        lock_d = (state_d == LOCKED);
    end

    assign sp_if.oMATCH  = match_q;
    assign sp_if.oERR    = err_q;
    assign sp_if.oLOCK   = lock_q;
    assign sp_if.oFRAMES = frames_q;

endmodule

// File: tb/tb_serial_pattern_checker.sv
// Self-checking bench for serial_pattern_checker (DIV=8, default pattern, LOCK_FRAMES=2).
module tb_serial_pattern_checker;
    localparam int unsigned DIV = 8;

    typedef struct {
        logic match;
        logic err;
        logic lock;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [9:0] pat;
    exp_t       exp_q[$];
    int         errors;
    int         checks;
    int         exp_frames;

    serial_pattern_checker_if sp_if ();

    serial_pattern_checker #(
        .DIV         (DIV),
        .PATTERN     (10'b1011011100),
        .LOCK_FRAMES (2)
    ) dut (
        .iCLK  (clk),
        .iRST  (rst),
        .sp_if (sp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset(input int n);
        rst = 1'b1;
        sp_if.iSIG = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        exp_frames = 0;
        exp_q.delete();
    endtask

    // Drive one bit period; the result of its mid-bit sample lands inside this window
    task automatic drive_bit(input string tag, input logic b, input logic em,
                             input logic ee, input logic el);
        exp_t e;
        int   nm;
        int   ne;
        int   both;
        nm = 0;
        ne = 0;
        both = 0;
        sp_if.iSIG = b;
        e.match = em;
        e.err   = ee;
        e.lock  = el;
        exp_q.push_back(e);
        if (em && exp_frames < 255) exp_frames++;
        repeat (DIV) begin
            @(negedge clk);
            if (sp_if.oMATCH === 1'b1) nm++;
            if (sp_if.oERR === 1'b1) ne++;
            if (sp_if.oMATCH === 1'b1 && sp_if.oERR === 1'b1) both++;
        end
        e = exp_q.pop_front();
        checks++;
        if (nm !== int'(e.match)) begin
            errors++;
            $display("FAIL %s match_pulses: got %0d expected %0d", tag, nm, int'(e.match));
        end
        checks++;
        if (ne !== int'(e.err)) begin
            errors++;
            $display("FAIL %s err_pulses: got %0d expected %0d", tag, ne, int'(e.err));
        end
        checks++;
        if (sp_if.oLOCK !== e.lock) begin
            errors++;
            $display("FAIL %s lock: got %b expected %b", tag, sp_if.oLOCK, e.lock);
        end
        checks++;
        if (sp_if.oFRAMES !== 8'(exp_frames)) begin
            errors++;
            $display("FAIL %s frames: got %0d expected %0d", tag, sp_if.oFRAMES, exp_frames);
        end
        checks++;
        if (both != 0) begin
            errors++;
            $display("FAIL %s match_and_err_together: got %0d expected 0", tag, both);
        end
    endtask

    // One frame; err_pos >= 0 marks the bit expected to raise oERR
    task automatic send_frame(input string tag, input logic [9:0] f, input logic exp_match,
                              input logic lock_before, input logic lock_after,
                              input int err_pos);
        for (int i = 0; i < 10; i++) begin
            logic el;
            logic ee;
            ee = (i == err_pos);
            if (err_pos >= 0 && i >= err_pos) el = 1'b0;
            else if (i == 9) el = lock_after;
            else el = lock_before;
            drive_bit(tag, f[9-i], exp_match && (i == 9) && (err_pos < 0), ee, el);
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (sp_if.oMATCH !== 1'b0 || sp_if.oERR !== 1'b0 || sp_if.oLOCK !== 1'b0
            || sp_if.oFRAMES !== 8'd0) begin
            errors++;
            $display("FAIL %s outputs: got match=%b err=%b lock=%b frames=%0d expected all 0",
                     tag, sp_if.oMATCH, sp_if.oERR, sp_if.oLOCK, sp_if.oFRAMES);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sp_if.iSIG = 1'b0;
        repeat (3) begin
            @(negedge clk);
            sp_if.iSIG = ~sp_if.iSIG;
            check_idle("reset_hold");
        end
        sp_if.iSIG = 1'b0;
        rst = 1'b0;
        exp_frames = 0;
        exp_q.delete();
        repeat (20) begin
            @(negedge clk);
            check_idle("reset_release");
        end
    endtask

    task automatic test_acquisition();
        apply_reset(3);
        send_frame("acq_f1", pat, 1'b1, 1'b0, 1'b0, -1);
        send_frame("acq_f2", pat, 1'b1, 1'b0, 1'b1, -1);
        send_frame("acq_f3", pat, 1'b1, 1'b1, 1'b1, -1);
        send_frame("acq_f4", pat, 1'b1, 1'b1, 1'b1, -1);
    endtask

    task automatic test_leading_garbage();
        apply_reset(3);
        drive_bit("garbage_b0", 1'b0, 1'b0, 1'b0, 1'b0);
        drive_bit("garbage_b1", 1'b0, 1'b0, 1'b0, 1'b0);
        drive_bit("garbage_b2", 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame("garbage_frame", pat, 1'b1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_error_in_lock();
        logic [9:0] bad;
        bad = pat ^ 10'b0000100000;
        apply_reset(3);
        send_frame("err_f1", pat, 1'b1, 1'b0, 1'b0, -1);
        send_frame("err_f2", pat, 1'b1, 1'b0, 1'b1, -1);
        send_frame("err_bad", bad, 1'b0, 1'b1, 1'b0, 4);
        send_frame("err_relock1", pat, 1'b1, 1'b0, 1'b0, -1);
        send_frame("err_relock2", pat, 1'b1, 1'b0, 1'b1, -1);
    endtask

    task automatic test_reset_mid_op();
        apply_reset(3);
        send_frame("rmid_f1", pat, 1'b1, 1'b0, 1'b0, -1);
        send_frame("rmid_f2", pat, 1'b1, 1'b0, 1'b1, -1);
        for (int i = 0; i < 5; i++) begin
            drive_bit("rmid_prefix", pat[9-i], 1'b0, 1'b0, 1'b1);
        end
        // pos is now 5; reset lands before that bit's mid-bit sample
        sp_if.iSIG = pat[4];
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("rmid_reset");
        end
        rst = 1'b0;
        sp_if.iSIG = 1'b0;
        exp_frames = 0;
        exp_q.delete();
        repeat (2 * DIV) begin
            @(negedge clk);
            check_idle("rmid_after");
        end
    endtask

    task automatic test_back_to_back();
        apply_reset(3);
        for (int k = 0; k < 260; k++) begin
            send_frame("sat", pat, 1'b1, (k >= 2), (k >= 1), -1);
        end
        checks++;
        if (sp_if.oFRAMES !== 8'd255) begin
            errors++;
            $display("FAIL sat_final frames: got %0d expected 255", sp_if.oFRAMES);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_frames = 0;
        pat = 10'b1011011100;
        rst = 1'b1;
        sp_if.iSIG = 1'b0;
        test_reset();
        test_acquisition();
        test_leading_garbage();
        test_error_in_lock();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_pattern_checker.md
SERIAL_PATTERN_CHECKER -- requirements
Module: serial_pattern_checker

Interface
REQ-001 Parameter DIV, default 6250000, iCLK cycles per serial bit period, legal range 4 to 2^23-1.
REQ-002 Parameter PATTERN, default 10'b1011011100, 10-bit frame; the MSB is the first bit on the line.
REQ-003 Parameter LOCK_FRAMES, default 2, consecutive good frames required for lock, legal range 1 to 15.
REQ-004 iCLK  input  1  system clock; all logic is rising-edge triggered.
REQ-005 iRST  input  1  synchronous, active-high reset.
REQ-006 iSIG  input  1  serial line from the pattern generator, asynchronous to the bit timing.
REQ-007 oMATCH  output  1  one-cycle pulse per completed, correctly received frame.
REQ-008 oLOCK  output  1  high while the state is LOCKED.
REQ-009 oERR  output  1  one-cycle pulse on a bit mismatch in VERIFY or LOCKED.
REQ-010 oFRAMES  output  8  count of oMATCH pulses, saturating at 255.

Function
REQ-011 iSIG SHALL pass through a 2-flop synchronizer; all further logic uses the synchronized bit (sSIG).
REQ-012 The divider counter SHALL count 0..DIV-1 and wrap to 0.
REQ-013 A sample strobe SHALL occur in each cycle where the counter equals DIV/2 (integer division).
REQ-014 In SEARCH, any sSIG transition SHALL force the counter to 0 in the next cycle (bit-edge realignment).
REQ-015 VERIFY and LOCKED SHALL perform no realignment.
REQ-016 The state machine SHALL have the states SEARCH, VERIFY and LOCKED; the reset state is SEARCH.
REQ-017 SEARCH, on each strobe: shift sSIG into the LSB of a 10-bit shift register and increment a fill counter, saturating at 10.
REQ-018 SEARCH match: when the fill count is 10 and the post-shift register equals PATTERN, assert oMATCH, load good-count=1 and pos=0.
REQ-019 SEARCH match next state: LOCKED if LOCK_FRAMES==1, else VERIFY.
REQ-020 VERIFY and LOCKED, on each strobe: compare sSIG with PATTERN[9-pos], then advance pos 0..9 with wrap.
REQ-021 Frame complete: a matching sample at pos==9 SHALL assert oMATCH.
REQ-022 In VERIFY, a frame complete SHALL increment good-count; reaching LOCK_FRAMES SHALL move the state to LOCKED.
REQ-023 In LOCKED, good frames SHALL leave the state unchanged.
REQ-024 On a mismatch in VERIFY or LOCKED: assert oERR, go to SEARCH, and clear the shift register, fill counter, good-count and pos.
REQ-025 oMATCH and oERR SHALL be registered and assert in the cycle after the strobe that caused them.
REQ-026 oLOCK SHALL rise and fall in the same cycle as the state change.
REQ-027 oFRAMES SHALL increment on every oMATCH and hold at 255.
REQ-028 oMATCH and oERR SHALL never be high in the same cycle.
REQ-029 A strobe in the first cycle after iRST deassertion SHALL be handled as a normal SEARCH sample.

Reset
REQ-030 While iRST is high at a clock edge, all registers SHALL clear: synchronizer, divider, shift register, fill counter, good-count, pos.
REQ-031 Reset SHALL force the state to SEARCH and drive oMATCH=0, oLOCK=0, oERR=0, oFRAMES=0 from the next cycle.
REQ-032 Reset SHALL override every other event in the same cycle, including mid-frame and LOCKED operation.
REQ-033 Reset SHALL take effect without any clock-edge requirement on iSIG.

Verification (DIV=8, default PATTERN, LOCK_FRAMES=2)
REQ-034 Reset: hold iRST 3 cycles -> all outputs 0 and state SEARCH; iSIG toggling during reset produces no pulses.
REQ-035 Acquisition: continuous repeated 1011011100 at 8 cycles/bit -> first oMATCH after the 10th bit, oLOCK after the 2nd frame, oFRAMES increments once per 80 cycles.
REQ-036 Leading garbage: bits 0,0,1 then the frame -> no oMATCH before the frame's last bit, oMATCH after it.
REQ-037 Error in lock: once locked, flip bit 4 of one frame -> oERR single pulse at that bit, oLOCK falls the same cycle, relock after 2 further good frames.
REQ-038 Reset mid-operation: assert iRST during LOCKED at pos=5 -> next cycle oLOCK=0, oFRAMES=0, and no oERR pulse.
REQ-039 Saturation: stream 260 good frames -> oFRAMES holds 255 while oMATCH keeps pulsing.
